vector_store_unit: RTL and testbench
====================================

VECTOR_STORE_UNIT -- requirements
Module: vector_store_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of 32-bit lanes per vector.
REQ-002 SHALL have parameter LANE_W, default 32, meaning lane and memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, store request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port in_data, input, LANES*LANE_W, vector to store; lane i = bits [32i+31:32i].
REQ-008 SHALL have port in_base, input, 32, byte address of lane 0.
REQ-009 SHALL have port in_stride, input, 8, word stride between lanes (unsigned).
REQ-010 SHALL have port in_mask, input, LANES, lane i written only when bit i = 1.
REQ-011 SHALL have ports mem_we (output, 1), mem_addr (output, 32) and mem_wdata (output, LANE_W), the word-write request to data memory.
REQ-012 SHALL have port mem_ready, input, 1, memory accepts the current write this cycle.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a request completes.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; every other state SHALL drive in_ready 0.
REQ-016 On in_valid && in_ready, SHALL register in_data, in_base, in_stride and in_mask, then select the lowest set mask bit as current lane.
REQ-017 After capture, SHALL go to WRITE if the mask is non-zero; a zero mask SHALL go directly to DONE with no mem_we.
REQ-018 In WRITE, mem_we SHALL be 1 and mem_wdata SHALL be the current lane's word.
REQ-019 In WRITE, mem_addr SHALL equal base + lane*stride*4, mod 2^32 (wrap-around silently).
REQ-020 While mem_ready = 0 in WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable.
REQ-021 On mem_ready = 1 in WRITE, SHALL advance to the next higher set mask bit in the same cycle.
REQ-022 Cleared mask lanes SHALL consume no cycles.
REQ-023 On acceptance of the last set lane, SHALL go to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be 1 + popcount(mask) + 1 cycles from acceptance to done with mem_ready held 1.
REQ-026 Lanes SHALL always be written in ascending lane order.
REQ-027 Stride 0 SHALL write all enabled lanes to in_base, last lane winning.
REQ-028 Changes on the in_* inputs while in_ready = 0 SHALL be ignored.
REQ-029 mem_we SHALL be 0 in IDLE and DONE.

Reset
REQ-030 rst SHALL force IDLE with in_ready=1, mem_we=0, done=0, mem_addr=0, mem_wdata=0, and clear the captured registers.
REQ-031 rst asserted mid-WRITE SHALL abandon the request with no further writes and no done pulse.
REQ-032 rst SHALL take priority over in_valid in the same cycle.

Structure
REQ-033 A shared package vsu_pkg SHALL hold the state enum, LANES, LANE_W and the byte-per-word constant (4).
REQ-034 There SHALL be no sub-module; lane select and address generation SHALL be inline.

Verification
REQ-035 Request base 0x100, stride 1, mask 4'b1111, data {D,C,B,A}, mem_ready=1 -> writes A@0x100, B@0x104, C@0x108, D@0x10C on consecutive cycles, then done one cycle later.
REQ-036 Request mask 4'b1010, stride 2, base 0x0 -> exactly two writes, lane1@0x8 and lane3@0x18, done 4 cycles after acceptance.
REQ-037 Request mask 4'b0000 -> no mem_we, done 2 cycles after acceptance.
REQ-038 Hold mem_ready=0 for 3 cycles on lane 0 of a full-mask request -> mem_addr/mem_wdata stable for those 3 cycles, then normal completion.
REQ-039 Request base 0xFFFFFFF8, stride 1, mask 4'b1111 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-040 Assert rst during the lane-2 write -> next cycle mem_we=0, in_ready=1, no done pulse; a new request then completes normally.

Source files
------------

// File: rtl/vsu_pkg.sv
// Shared definitions for the vector store unit: FSM encoding, default
// geometry and the byte-per-word scale used in address generation.
package vsu_pkg;

   localparam int LANES          = 4;
   localparam int LANE_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/vector_store_unit.sv
// Strided, masked vector store: scatters the enabled lanes of one captured
// vector to word memory in ascending lane order, one write per accepted cycle.
module vector_store_unit #(
   parameter int LANES  = vsu_pkg::LANES,
   parameter int LANE_W = vsu_pkg::LANE_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic [31:0]             in_base,
   input  logic [7:0]              in_stride,
   input  logic [LANES-1:0]        in_mask,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [LANE_W-1:0]       mem_wdata,
   input  logic                    mem_ready,
   output logic                    done
);

   import vsu_pkg::*;

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   state_t                  state_r;
   state_t                  state_next_s;

   logic [LANES*LANE_W-1:0] data_r;
   logic [31:0]             base_r;
   logic [7:0]              stride_r;
   logic [LANES-1:0]        mask_r;
   logic [IDX_W-1:0]        lane_r;

   logic                    in_ready_r;
   logic                    mem_we_r;
   logic [31:0]             mem_addr_r;
   logic [LANE_W-1:0]       mem_wdata_r;
   logic                    done_r;

   logic                    accept_s;
   logic                    advance_s;
   logic [LANES-1:0]        remain_s;
   logic [LANES-1:0]        src_mask_s;
   logic [31:0]             src_base_s;
   logic [7:0]              src_stride_s;
   logic [LANES*LANE_W-1:0] src_data_s;
   logic [IDX_W-1:0]        pick_s;
   logic [31:0]             addr_s;
   logic [LANE_W-1:0]       word_s;

   assign in_ready  = in_ready_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign done      = done_r;

   // Lane selection and address generation for the next write, sourced from
   // the live inputs at acceptance and from the captured request afterwards.
   always_comb begin
      accept_s  = in_valid && (state_r == IDLE);
      advance_s = mem_ready && (state_r == WRITE);

      remain_s         = mask_r;
      remain_s[lane_r] = 1'b0;

      if (state_r == IDLE) begin
         src_mask_s   = in_mask;
         src_base_s   = in_base;
         src_stride_s = in_stride;
         src_data_s   = in_data;
      end else begin
         src_mask_s   = remain_s;
         src_base_s   = base_r;
         src_stride_s = stride_r;
         src_data_s   = data_r;
      end

      // Scanning downward leaves the lowest set bit selected.
      pick_s = {IDX_W{1'b0}};
      for (int i = LANES - 1; i >= 0; i--) begin
         if (src_mask_s[i]) begin
            pick_s = IDX_W'(i);
         end else begin
            pick_s = pick_s;
         end
      end

      addr_s = src_base_s + (32'(pick_s) * 32'(src_stride_s) * 32'(BYTES_PER_WORD));
      word_s = src_data_s[32'(pick_s) * LANE_W +: LANE_W];
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next_s = (|in_mask) ? WRITE : DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         WRITE: begin
            if (mem_ready) begin
               state_next_s = (|remain_s) ? WRITE : DONE;
            end else begin
               state_next_s = WRITE;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Captured request and registered memory/handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r      <= {(LANES*LANE_W){1'b0}};
         base_r      <= 32'd0;
         stride_r    <= 8'd0;
         mask_r      <= {LANES{1'b0}};
         lane_r      <= {IDX_W{1'b0}};
         in_ready_r  <= 1'b1;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= {LANE_W{1'b0}};
         done_r      <= 1'b0;
      end else begin
         in_ready_r <= (state_next_s == IDLE);
         // done trails the DONE state by one cycle and lasts exactly one.
         done_r     <= (state_r == DONE);
         if (accept_s) begin
            data_r   <= in_data;
            base_r   <= in_base;
            stride_r <= in_stride;
            mask_r   <= in_mask;
            lane_r   <= pick_s;
            mem_we_r <= |in_mask;
            if (|in_mask) begin
               mem_addr_r  <= addr_s;
               mem_wdata_r <= word_s;
            end else begin
               mem_addr_r  <= mem_addr_r;
               mem_wdata_r <= mem_wdata_r;
            end
         end else if (advance_s) begin
            mask_r   <= remain_s;
            lane_r   <= pick_s;
            mem_we_r <= |remain_s;
            if (|remain_s) begin
               mem_addr_r  <= addr_s;
               mem_wdata_r <= word_s;
            end else begin
               mem_addr_r  <= mem_addr_r;
               mem_wdata_r <= mem_wdata_r;
            end
         end else begin
            mem_we_r <= mem_we_r && (state_r == WRITE);
         end
      end
   end

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed, table-driven bench for vector_store_unit with hand-computed
// write sequences, stall, wrap-around and reset corner cases.
module tb_vector_store_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [31:0]  in_base;
   logic [7:0]   in_stride;
   logic [3:0]   in_mask;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_ready;
   logic         done;

   always #5 clk = ~clk;

   vector_store_unit #(.LANES(4), .LANE_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_base(in_base), .in_stride(in_stride),
      .in_mask(in_mask), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .done(done)
   );

   typedef struct {
      string             name;
      logic [31:0]       base;
      logic [7:0]        stride;
      logic [3:0]        mask;
      logic [127:0]      data;
      int                stall;
      int                n;
      logic [3:0][31:0]  addr;
      logic [3:0][31:0]  wdata;
      int                lat;
   } vec_t;

   vec_t        vecs [7];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] got_addr [8];
   logic [31:0] got_data [8];
   int          got_n;
   int          got_lat;

   localparam logic [127:0] DATA_A = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
   localparam logic [127:0] DATA_B = {32'h1357_9BDF, 32'h0246_8ACE, 32'hFEDC_BA98, 32'h7654_3210};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v);
      @(negedge clk);
      in_valid  = 1'b1;
      in_base   = v.base;
      in_stride = v.stride;
      in_mask   = v.mask;
      in_data   = v.data;
      mem_ready = (v.stall == 0);
      chk({v.name, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      // Scramble the request inputs; the captured request must be unaffected.
      in_valid  = 1'b0;
      in_base   = 32'hDEAD_BEEF;
      in_stride = 8'hFF;
      in_mask   = 4'hF;
      in_data   = {4{32'h5A5A_5A5A}};
      got_n     = 0;
      got_lat   = -1;
      chk({v.name, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      for (int cyc = 1; cyc <= 60; cyc++) begin
         mem_ready = (cyc > v.stall);
         if (cyc <= v.stall) begin
            chk({v.name, " stall_we"},   {31'd0, mem_we}, 32'd1);
            chk({v.name, " stall_addr"}, mem_addr, v.addr[0]);
            chk({v.name, " stall_data"}, mem_wdata, v.wdata[0]);
         end
         if (mem_we && mem_ready) begin
            if (got_n < 8) begin
               got_addr[got_n] = mem_addr;
               got_data[got_n] = mem_wdata;
            end
            got_n++;
         end
         if (done) begin
            got_lat = cyc;
            break;
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      chk({v.name, " latency"}, got_lat, v.lat);
      chk({v.name, " write_count"}, got_n, v.n);
      for (int i = 0; i < v.n; i++) begin
         if (i < got_n) begin
            chk($sformatf("%s addr%0d", v.name, i), got_addr[i], v.addr[i]);
            chk($sformatf("%s data%0d", v.name, i), got_data[i], v.wdata[i]);
         end
      end
      @(negedge clk);
      chk({v.name, " done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      bit seen;
      bit found;

      vecs[0] = '{"full", 32'h0000_0100, 8'd1, 4'b1111, DATA_A, 0, 4,
                  {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100},
                  {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 6};
      vecs[1] = '{"sparse", 32'h0000_0000, 8'd2, 4'b1010, DATA_B, 0, 2,
                  {32'h0, 32'h0, 32'h0000_0018, 32'h0000_0008},
                  {32'h0, 32'h0, 32'h1357_9BDF, 32'hFEDC_BA98}, 4};
      vecs[2] = '{"empty", 32'h0000_0500, 8'd1, 4'b0000, DATA_A, 0, 0,
                  {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0}, 2};
      vecs[3] = '{"wrap", 32'hFFFF_FFF8, 8'd1, 4'b1111, DATA_B, 0, 4,
                  {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                  {32'h1357_9BDF, 32'h0246_8ACE, 32'hFEDC_BA98, 32'h7654_3210}, 6};
      vecs[4] = '{"stride0", 32'h0000_0040, 8'd0, 4'b0110, DATA_A, 0, 2,
                  {32'h0, 32'h0, 32'h0000_0040, 32'h0000_0040},
                  {32'h0, 32'h0, 32'hCCCC_0002, 32'hBBBB_0001}, 4};
      vecs[5] = '{"stride255", 32'h0000_1000, 8'd255, 4'b1001, DATA_B, 0, 2,
                  {32'h0, 32'h0, 32'h0000_1BF4, 32'h0000_1000},
                  {32'h0, 32'h0, 32'h1357_9BDF, 32'h7654_3210}, 4};
      vecs[6] = '{"stall", 32'h0000_0200, 8'd1, 4'b1111, DATA_A, 3, 4,
                  {32'h0000_020C, 32'h0000_0208, 32'h0000_0204, 32'h0000_0200},
                  {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 9};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_base   = 32'd0;
      in_stride = 8'd0;
      in_mask   = 4'd0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset in_ready",  {31'd0, in_ready}, 32'd1);
      chk("reset mem_we",    {31'd0, mem_we},   32'd0);
      chk("reset done",      {31'd0, done},     32'd0);
      chk("reset mem_addr",  mem_addr,          32'd0);
      chk("reset mem_wdata", mem_wdata,         32'd0);
      rst = 1'b0;

      for (int k = 0; k < 7; k++) begin
         run_req(vecs[k]);
      end

      // Reset during the lane-2 write abandons the request silently.
      @(negedge clk);
      in_valid  = 1'b1;
      in_base   = 32'h0000_0300;
      in_stride = 8'd1;
      in_mask   = 4'b1111;
      in_data   = DATA_A;
      mem_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      found    = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (mem_we && mem_addr == 32'h0000_0308) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rst reached_lane2", {31'd0, found}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mem_we",   {31'd0, mem_we},   32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst done",     {31'd0, done},     32'd0);
      chk("rst mem_addr", mem_addr,          32'd0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || mem_we) seen = 1'b1;
      end
      chk("rst no_activity_after", {31'd0, seen}, 32'd0);
      run_req(vecs[1]);

      // Reset wins over a simultaneous request.
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_mask  = 4'b1111;
      in_base  = 32'h0000_0700;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_prio in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_prio mem_we",   {31'd0, mem_we},   32'd0);
      @(negedge clk);
      chk("rst_prio no_write", {31'd0, mem_we},   32'd0);
      chk("rst_prio no_done",  {31'd0, done},     32'd0);

      run_req(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
